// File: rtl/isr_pkg.sv
// Shared constants, FSM state type and cause names for the interrupt sequencer.
// Optional nesting support in isr_ctrl is enabled with `define ISR_CTRL_NEST_EN.
package isr_pkg;

  localparam int NCAUSE = 23;
  localparam int NINT   = 6;
  localparam int EW     = 5;
  localparam int NEST_MAX = 3;

  localparam logic [NCAUSE-1:0] RPT_MASK_DFLT = 23'h000006;

  // Named cause indices
  localparam int CA_ILL  = 0;
  localparam int CA_PFF  = 1;
  localparam int CA_PFLS = 2;
  localparam int CA_TRAP = 3;
  localparam int CA_OVF  = 5;
  localparam int CA_EXT0 = 6;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_JISR    = 2'd1,
    ST_HANDLER = 2'd2,
    ST_RETURN  = 2'd3
  } isr_state_e;

  // Observation bundle: FSM state, nest depth and the pending register.
  typedef struct packed {
    isr_state_e        state;
    logic [1:0]        depth;
    logic [NCAUSE-1:0] pend;
  } isr_dbg_t;

  // Internal causes are non-maskable, so their enable bits are forced on.
  function automatic logic [NCAUSE-1:0] cause_enable(input logic [NCAUSE-1:0] sr);
    return sr | {{(NCAUSE-NINT){1'b0}}, {NINT{1'b1}}};
  endfunction

endpackage

// File: rtl/prio_enc23.sv
// Lowest-index-first priority encoder over the 23-bit cause vector.
module prio_enc23
  import isr_pkg::*;
(
  input  logic [NCAUSE-1:0] req,
  output logic [EW-1:0]     idx,
  output logic              vld
);

  // Scan from the top down so the last hit, the lowest index, wins.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = NCAUSE - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = EW'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/isr_ctrl.sv
// Interrupt sequencer: pending/mask logic, jump-to-ISR pulse and handler tracking.
// Define ISR_CTRL_NEST_EN to allow higher-priority causes to nest up to 3 deep.
module isr_ctrl #(
  parameter int NCAUSE = isr_pkg::NCAUSE,
  parameter int NINT   = isr_pkg::NINT,
  parameter logic [NCAUSE-1:0] RPT_MASK = isr_pkg::RPT_MASK_DFLT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCAUSE-1:0]  ca,
  input  logic [NCAUSE-1:0]  sr,
  input  logic [NCAUSE-1:0]  ca_clr,
  input  logic               ca_clr_we,
  input  logic               stall,
  input  logic               eret,
  output logic               jisr,
  output logic [NCAUSE-1:0]  mca,
  output logic               rpt,
  output logic [4:0]         eca,
  output logic               in_isr,
  output isr_pkg::isr_dbg_t  dbg
);

  import isr_pkg::*;

  isr_state_e        state;
  logic [NCAUSE-1:0] pend;
  logic [NCAUSE-1:0] m;
  logic [NCAUSE-1:0] clr;
  logic [NCAUSE-1:0] svc;
  logic [EW-1:0]     low;
  logic              low_vld;
  logic              take;
  logic [1:0]        depth;

  assign m   = pend & cause_enable(sr);
  assign clr = ca_clr_we ? ca_clr : '0;

  prio_enc23 u_enc (
    .req (m),
    .idx (low),
    .vld (low_vld)
  );

  always_comb begin
    take = 1'b0;
    if (low_vld && !stall) begin
      if (state == ST_RUN) begin
        take = 1'b1;
      end
`ifdef ISR_CTRL_NEST_EN
      else if (state == ST_HANDLER && !eret && low < eca && depth != 2'd3) begin
        take = 1'b1;
      end
`endif
    end
  end

  // Internal pulse causes are consumed when serviced; external lines stay
  // pending until the handler clears them.
  always_comb begin
    svc = '0;
    if (take && int'(low) < NINT) begin
      svc[low] = 1'b1;
    end
  end

`ifdef ISR_CTRL_NEST_EN
  logic [EW-1:0] stack [NEST_MAX];

  always_ff @(posedge clk) begin
    if (rst) begin
      depth <= 2'd0;
      for (int i = 0; i < NEST_MAX; i++) begin
        stack[i] <= '0;
      end
    end else if (state == ST_HANDLER) begin
      if (eret) begin
        if (depth != 2'd0) begin
          depth <= depth - 2'd1;
        end
      end else if (take) begin
        stack[depth] <= eca;
        depth        <= depth + 2'd1;
      end
    end
  end
`else
  assign depth = 2'd0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_RUN;
      pend   <= '0;
      jisr   <= 1'b0;
      mca    <= '0;
      rpt    <= 1'b0;
      eca    <= '0;
      in_isr <= 1'b0;
    end else begin
      // Set wins over clear for the same bit.
      pend <= (pend & ~clr & ~svc) | ca;
      jisr <= 1'b0;
      case (state)
        ST_RUN: begin
          if (take) begin
            state <= ST_JISR;
            jisr  <= 1'b1;
            mca   <= m;
            eca   <= low;
            rpt   <= RPT_MASK[low];
          end
        end
        ST_JISR: begin
          state  <= ST_HANDLER;
          in_isr <= 1'b1;
        end
        ST_HANDLER: begin
          if (eret) begin
            state <= ST_RETURN;
`ifdef ISR_CTRL_NEST_EN
            if (depth != 2'd0) begin
              eca <= stack[depth - 2'd1];
            end else begin
              in_isr <= 1'b0;
            end
`else
            in_isr <= 1'b0;
`endif
          end
`ifdef ISR_CTRL_NEST_EN
          else if (take) begin
            state <= ST_JISR;
            jisr  <= 1'b1;
            mca   <= m;
            eca   <= low;
            rpt   <= RPT_MASK[low];
          end
`endif
        end
        ST_RETURN: begin
          // in_isr still set here means an outer handler is being resumed.
          state <= in_isr ? ST_HANDLER : ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign dbg = '{state: state, depth: depth, pend: pend};

endmodule

// File: tb/tb_isr_ctrl.sv
// Bench for isr_ctrl: directed vector table, hand sequences, and random stimulus vs. a reference model.
module tb_isr_ctrl;
  import isr_pkg::*;

`ifdef ISR_CTRL_NEST_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [22:0] ca, sr, ca_clr;
  logic        ca_clr_we, stall, eret;
  logic        jisr, rpt, in_isr;
  logic [22:0] mca;
  logic [4:0]  eca;
  isr_dbg_t    dbg;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  isr_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .ca        (ca),
    .sr        (sr),
    .ca_clr    (ca_clr),
    .ca_clr_we (ca_clr_we),
    .stall     (stall),
    .eret      (eret),
    .jisr      (jisr),
    .mca       (mca),
    .rpt       (rpt),
    .eca       (eca),
    .in_isr    (in_isr),
    .dbg       (dbg)
  );

  typedef struct {
    logic        rst;
    logic [22:0] ca, sr, clr;
    logic        we, stall, eret;
    logic        xj, xi;
    logic [4:0]  xe;
    logic [22:0] xm;
    logic        xr;
    logic [22:0] xp;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [22:0] c, s, cl, input logic w, st, er,
                              input logic xj, xi, input logic [4:0] xe, input logic [22:0] xm,
                              input logic xr, input logic [22:0] xp);
    vec_t v;
    v.rst = r; v.ca = c; v.sr = s; v.clr = cl; v.we = w; v.stall = st; v.eret = er;
    v.xj = xj; v.xi = xi; v.xe = xe; v.xm = xm; v.xr = xr; v.xp = xp;
    return v;
  endfunction

  task automatic check(input string name, input logic xj, xi, input logic [4:0] xe,
                       input logic [22:0] xm, input logic xr, input logic [22:0] xp);
    vectors++;
    if (jisr !== xj || in_isr !== xi || eca !== xe || mca !== xm || rpt !== xr || dbg.pend !== xp) begin
      miscompares++;
      $display("FAIL %s: got jisr=%0b in_isr=%0b eca=%0d mca=%06h rpt=%0b pend=%06h; need jisr=%0b in_isr=%0b eca=%0d mca=%06h rpt=%0b pend=%06h",
               name, jisr, in_isr, eca, mca, rpt, dbg.pend, xj, xi, xe, xm, xr, xp);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    rst = v.rst; ca = v.ca; sr = v.sr; ca_clr = v.clr;
    ca_clr_we = v.we; stall = v.stall; eret = v.eret;
    @(posedge clk);
    #1;
    check(name, v.xj, v.xi, v.xe, v.xm, v.xr, v.xp);
  endtask

  // Reference model: pending bits, a stack of active handler causes,
  // and flags for the one-cycle jump pulse and the one-cycle return gap.
  logic [22:0] p_m;
  bit          pulse_m, ret_m;
  int          hq[$];
  logic        xj_m, xi_m, xr_m;
  logic [4:0]  xe_m;
  logic [22:0] xm_m;
  logic [22:0] rpt_bits = 23'h000006;

  task automatic model_reset();
    p_m = '0; pulse_m = 0; ret_m = 0; hq.delete();
    xj_m = 0; xi_m = 0; xe_m = '0; xm_m = '0; xr_m = 0;
  endtask

  task automatic model_step();
    logic [22:0] mv, svcv;
    int  low;
    bit  idle, busy, fire;
    mv   = p_m & {sr[22:6], 6'h3F};
    low  = -1;
    for (int i = 0; i < 23; i++) if (mv[i] && low < 0) low = i;
    idle = !pulse_m && !ret_m && hq.size() == 0;
    busy = !pulse_m && !ret_m && hq.size() > 0;
    fire = low >= 0 && !stall &&
           (idle || (NEST && busy && !eret && low < hq[$] && hq.size() < 4));
    svcv = '0;
    if (fire && low < 6) svcv[low] = 1'b1;
    p_m  = (p_m & ~(ca_clr_we ? ca_clr : 23'h0) & ~svcv) | ca;
    xj_m = fire;
    if (fire) begin
      xm_m = mv; xe_m = 5'(low); xr_m = rpt_bits[low];
      hq.push_back(low); pulse_m = 1; xi_m = busy;
    end else if (pulse_m) begin
      pulse_m = 0; xi_m = 1;
    end else if (ret_m) begin
      ret_m = 0; xi_m = hq.size() > 0;
    end else if (busy && eret) begin
      void'(hq.pop_back());
      ret_m = 1;
      xi_m = hq.size() > 0;
      if (hq.size() > 0) xe_m = 5'(hq[$]);
    end
  endtask

  vec_t tbl[44];

  initial begin
    logic [16:0] ext;
    logic [5:0]  intp;
    rst = 1'b0; ca = '0; sr = '0; ca_clr = '0; ca_clr_we = 0; stall = 0; eret = 0;

    //            rst ca      sr      clr     we st er   jisr in  eca mca     rpt pend
    tbl[0]  = mk(1, 0,      0,      0,      0, 0, 0,   0,   0,  0,  0,      0,  0);
    tbl[1]  = mk(0, 'h8,    0,      0,      0, 0, 0,   0,   0,  0,  0,      0,  'h8);
    tbl[2]  = mk(0, 0,      0,      0,      0, 0, 0,   1,   0,  3,  'h8,    0,  0);
    tbl[3]  = mk(0, 0,      0,      0,      0, 0, 0,   0,   1,  3,  'h8,    0,  0);
    tbl[4]  = mk(0, 0,      0,      0,      0, 0, 1,   0,   0,  3,  'h8,    0,  0);
    tbl[5]  = mk(0, 0,      0,      0,      0, 0, 0,   0,   0,  3,  'h8,    0,  0);
    tbl[6]  = mk(0, 'h24,   0,      0,      0, 0, 0,   0,   0,  3,  'h8,    0,  'h24);
    tbl[7]  = mk(0, 0,      0,      0,      0, 0, 0,   1,   0,  2,  'h24,   1,  'h20);
    tbl[8]  = mk(0, 0,      0,      0,      0, 0, 0,   0,   1,  2,  'h24,   1,  'h20);
    tbl[9]  = mk(0, 0,      0,      0,      0, 0, 1,   0,   0,  2,  'h24,   1,  'h20);
    tbl[10] = mk(0, 0,      0,      0,      0, 0, 0,   0,   0,  2,  'h24,   1,  'h20);
    tbl[11] = mk(0, 0,      0,      0,      0, 0, 0,   1,   0,  5,  'h20,   0,  0);
    tbl[12] = mk(0, 0,      0,      0,      0, 0, 0,   0,   1,  5,  'h20,   0,  0);
    tbl[13] = mk(0, 0,      0,      0,      0, 0, 1,   0,   0,  5,  'h20,   0,  0);
    tbl[14] = mk(0, 0,      0,      0,      0, 0, 0,   0,   0,  5,  'h20,   0,  0);
    tbl[15] = mk(0, 'h2,    0,      0,      0, 1, 0,   0,   0,  5,  'h20,   0,  'h2);
    for (int i = 16; i < 20; i++)
      tbl[i] = mk(0, 0,     0,      0,      0, 1, 0,   0,   0,  5,  'h20,   0,  'h2);
    tbl[20] = mk(0, 0,      0,      0,      0, 0, 0,   1,   0,  1,  'h2,    1,  0);
    tbl[21] = mk(0, 0,      0,      0,      0, 0, 0,   0,   1,  1,  'h2,    1,  0);
    tbl[22] = mk(0, 0,      0,      0,      0, 1, 1,   0,   0,  1,  'h2,    1,  0);
    tbl[23] = mk(0, 0,      0,      0,      0, 0, 0,   0,   0,  1,  'h2,    1,  0);
    for (int i = 24; i < 28; i++)
      tbl[i] = mk(0, 'h40,  0,      0,      0, 0, 0,   0,   0,  1,  'h2,    1,  'h40);
    tbl[28] = mk(0, 'h40,   'h40,   0,      0, 0, 0,   1,   0,  6,  'h40,   0,  'h40);
    tbl[29] = mk(0, 'h40,   'h40,   0,      0, 0, 0,   0,   1,  6,  'h40,   0,  'h40);
    tbl[30] = mk(0, 'h40,   'h40,   'h40,   1, 0, 0,   0,   1,  6,  'h40,   0,  'h40);
    tbl[31] = mk(0, 0,      'h40,   0,      0, 0, 0,   0,   1,  6,  'h40,   0,  'h40);
    tbl[32] = mk(0, 0,      'h40,   0,      0, 0, 1,   0,   0,  6,  'h40,   0,  'h40);
    tbl[33] = mk(0, 0,      'h40,   0,      0, 0, 0,   0,   0,  6,  'h40,   0,  'h40);
    tbl[34] = mk(0, 0,      'h40,   0,      0, 0, 0,   1,   0,  6,  'h40,   0,  'h40);
    tbl[35] = mk(0, 0,      'h40,   'h40,   1, 0, 0,   0,   1,  6,  'h40,   0,  0);
    tbl[36] = mk(0, 0,      'h40,   0,      0, 0, 1,   0,   0,  6,  'h40,   0,  0);
    tbl[37] = mk(0, 0,      'h40,   0,      0, 0, 0,   0,   0,  6,  'h40,   0,  0);
    tbl[38] = mk(0, 0,      'h40,   0,      0, 0, 0,   0,   0,  6,  'h40,   0,  0);
    tbl[39] = mk(0, 'h1,    'h40,   0,      0, 0, 0,   0,   0,  6,  'h40,   0,  'h1);
    tbl[40] = mk(0, 0,      'h40,   0,      0, 0, 0,   1,   0,  0,  'h1,    0,  0);
    tbl[41] = mk(0, 'h8,    'h40,   0,      0, 0, 0,   0,   1,  0,  'h1,    0,  'h8);
    tbl[42] = mk(1, 0,      'h40,   0,      0, 0, 0,   0,   0,  0,  0,      0,  0);
    tbl[43] = mk(0, 0,      'h40,   0,      0, 0, 0,   0,   0,  0,  0,      0,  0);

    for (int i = 0; i < 44; i++) begin
      apply(tbl[i], $sformatf("tbl%0d", i));
      if (tbl[i].rst) begin
        vectors++;
        if (dbg.state !== ST_RUN || dbg.depth !== 2'd0) begin
          miscompares++;
          $display("FAIL rst_state%0d: got state=%0d depth=%0d, need state=0 depth=0", i, dbg.state, dbg.depth);
        end
      end
    end

    // Low-index internal cause arriving while an external handler runs.
    apply(mk(0, 'h40, 'h40, 0, 0, 0, 0,  0, 0, 0, 0,     0, 'h40), "nest0");
    apply(mk(0, 0,    'h40, 0, 0, 0, 0,  1, 0, 6, 'h40,  0, 'h40), "nest1");
    apply(mk(0, 0,    'h40, 0, 0, 0, 0,  0, 1, 6, 'h40,  0, 'h40), "nest2");
    apply(mk(0, 'h1,  'h40, 0, 0, 0, 0,  0, 1, 6, 'h40,  0, 'h41), "nest3");
`ifdef ISR_CTRL_NEST_EN
    apply(mk(0, 0, 'h40, 0,    0, 0, 0,  1, 1, 0, 'h41,  0, 'h40), "nest4");
    apply(mk(0, 0, 'h40, 0,    0, 0, 0,  0, 1, 0, 'h41,  0, 'h40), "nest5");
    apply(mk(0, 0, 'h40, 0,    0, 0, 1,  0, 1, 6, 'h41,  0, 'h40), "nest6");
    apply(mk(0, 0, 'h40, 0,    0, 0, 0,  0, 1, 6, 'h41,  0, 'h40), "nest7");
    apply(mk(0, 0, 'h40, 'h40, 1, 0, 0,  0, 1, 6, 'h41,  0, 0),     "nest8");
    apply(mk(0, 0, 'h40, 0,    0, 0, 1,  0, 0, 6, 'h41,  0, 0),     "nest9");
    apply(mk(0, 0, 'h40, 0,    0, 0, 0,  0, 0, 6, 'h41,  0, 0),     "nest10");
    apply(mk(0, 0, 'h40, 0,    0, 0, 0,  0, 0, 6, 'h41,  0, 0),     "nest11");
`else
    apply(mk(0, 0, 'h40, 0,    0, 0, 0,  0, 1, 6, 'h40,  0, 'h41),  "nest4");
    apply(mk(0, 0, 'h40, 'h40, 1, 0, 0,  0, 1, 6, 'h40,  0, 'h1),   "nest5");
    apply(mk(0, 0, 'h40, 0,    0, 0, 1,  0, 0, 6, 'h40,  0, 'h1),   "nest6");
    apply(mk(0, 0, 'h40, 0,    0, 0, 0,  0, 0, 6, 'h40,  0, 'h1),   "nest7");
    apply(mk(0, 0, 'h40, 0,    0, 0, 0,  1, 0, 0, 'h1,   0, 0),     "nest8");
    apply(mk(0, 0, 'h40, 0,    0, 0, 0,  0, 1, 0, 'h1,   0, 0),     "nest9");
    apply(mk(0, 0, 'h40, 0,    0, 0, 1,  0, 0, 0, 'h1,   0, 0),     "nest10");
    apply(mk(0, 0, 'h40, 0,    0, 0, 0,  0, 0, 0, 'h1,   0, 0),     "nest11");
`endif

    // Random traffic checked every cycle against the reference model.
    ext = '0;
    sr  = 23'($urandom);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst  = (cyc == 0) || ($urandom_range(0, 499) == 0);
      intp = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(1, 63)) : 6'h0;
      if ($urandom_range(0, 15) == 0) ext = ext ^ (17'h1 << $urandom_range(0, 16));
      if ($urandom_range(0, 31) == 0) sr = 23'($urandom);
      ca        = {ext, intp};
      ca_clr    = 23'($urandom);
      ca_clr_we = ($urandom_range(0, 3) == 0);
      stall     = ($urandom_range(0, 3) == 0);
      eret      = ($urandom_range(0, 5) == 0);
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      #1;
      check($sformatf("rand%0d", cyc), xj_m, xi_m, xe_m, xm_m, xr_m, p_m);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/isr_ctrl.md
# isr_ctrl

Interrupt sequencer sitting between the pipeline's cause sources and the special-purpose register file. It collects interrupt causes into a pending register and applies the status mask. When the pipeline can accept it, it raises the one-cycle `jisr` pulse together with `mca` and `rpt`, which the SPR file captures. It then holds handler state until `eret` and returns the core to normal execution.

## Interface
Parameters:
- `NCAUSE`, 23: cause vector width; matches the SPR `mca` field.
- `NINT`, 6: causes `[NINT-1:0]` are internal: pulse sources, non-maskable.
- `RPT_MASK`, 23'h000006: cause bits whose service requires re-executing the faulting instruction.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `ca` in 23: raw causes. `[5:0]` are internal single-cycle pulses; `[22:6]` are external level lines.
- `sr` in 23: status mask. Only bits `[22:6]` are used; 1 enables the cause.
- `ca_clr` in 23: write-1-to-clear for pending bits, qualified by `ca_clr_we`.
- `ca_clr_we` in 1: handler clear strobe.
- `stall` in 1: pipeline cannot take a jump this cycle.
- `eret` in 1: return-from-exception retired.
- `jisr` out 1: one-cycle jump-to-ISR pulse, registered.
- `mca` out 23: masked cause vector, registered, valid while `jisr`=1.
- `rpt` out 1: the highest-priority serviced cause is in `RPT_MASK`, valid with `jisr`.
- `eca` out 5: index of the highest-priority serviced cause.
- `in_isr` out 1: handler active.

## Operation
- Pending register `pend`:
  - Each cycle: `pend <= (pend & ~clr) | ca`.
  - `clr` = `ca_clr` when `ca_clr_we`=1.
  - Simultaneous set and clear of the same bit: set wins.
- Masked vector: `m = pend & {sr[22:6], 6'h3F}`. Priority is lowest index first.
- FSM states:
  - RUN:
    - If `m`≠0 and `stall`=0: go to JISR.
    - Register `mca`=`m`, `eca`=index of the lowest set bit, `rpt`=`RPT_MASK[eca]`.
    - Clear the serviced bit in `pend` if `eca`<`NINT`. External bits stay pending until software clears them.
  - JISR: one cycle with `jisr`=1, then go to HANDLER.
  - HANDLER:
    - `in_isr`=1.
    - All causes are held pending and no further `jisr` fires, except as allowed under Configuration.
    - `eret`=1: go to RETURN.
  - RETURN: one cycle with `in_isr`=0 and `jisr` suppressed, then RUN.
- `eret` in RUN or JISR is ignored.
- `stall` in RUN defers the jump. The `mca` reported is the one computed in the cycle where `stall` drops.
- An external cause that is masked stays pending. It fires once `sr` enables it while the FSM is in RUN.

## Timing
- Reset values:
  - state RUN, `pend`=0.
  - `jisr`=0, `mca`=0, `rpt`=0, `eca`=0, `in_isr`=0.
  - nest depth 0.
- Latency:
  - Cause asserted in cycle t with FSM in RUN and `stall`=0: internal pend visible t+1, FSM enters JISR at t+2, `jisr`=1 in cycle t+2.
  - `in_isr`=1 from t+3.
- `eret` in cycle e: RETURN at e+1, RUN at e+2. The earliest next `jisr` is e+3.
- `rst` mid-handler: FSM returns to RUN and `pend` is cleared on the same edge.
- `mca`, `eca` and `rpt` hold their values until the next JISR.

## Configuration
- Macro `ISR_CTRL_NEST_EN`.
- Defined:
  - In HANDLER, a pending cause with index strictly lower than the current `eca` re-enters JISR through the normal path.
  - A 2-bit depth counter and a 3-entry `eca` stack are added.
  - On `eret` with depth>0: depth decrements, `eca` pops, the FSM returns to HANDLER through RETURN, and `in_isr` stays 1.
  - At depth 3, further nesting is blocked.
- Undefined: no nesting; HANDLER exits only through `eret`; counter and stack are absent.

## Structure
- Shared package `isr_pkg`:
  - constants `NCAUSE`, `NINT`, default `RPT_MASK`;
  - FSM state enum;
  - named cause indices (e.g. `CA_ILL`=0, `CA_PFF`=1, `CA_PFLS`=2, `CA_TRAP`=3, `CA_OVF`=5, `CA_EXT0`=6).
- One sub-module, `prio_enc23`: combinational lowest-index-first encoder producing a 5-bit index and a valid flag.

## Test plan
- Trap, no stall:
  - stimulus: `ca[3]` pulsed at cycle 10, `sr`=0, `stall`=0;
  - response: `jisr` at cycle 12, `mca`=23'h000008, `eca`=3, `rpt`=0, `in_isr`=1 from 13, `pend[3]`=0.
- Page fault with stall:
  - stimulus: `ca[1]` pulsed, `stall`=1 for 5 cycles;
  - response: no `jisr` while stalled, then `jisr` the cycle after `stall` drops, with `rpt`=1 and `eca`=1.
- Masked external cause:
  - stimulus: `ca[6]` held at 1 with `sr[6]`=0 for 20 cycles, then `sr[6]`=1;
  - response: no `jisr` before the unmask, `jisr` 1 cycle after, `mca[6]`=1;
  - then `ca_clr[6]` with `ca_clr_we`=1 clears `pend[6]` only once `ca[6]`=0.
- Priority:
  - stimulus: `ca[5]` and `ca[2]` pulsed in the same cycle;
  - response: `eca`=2, `mca`=23'h000024;
  - after `eret` the second `jisr` has `eca`=5, no earlier than `eret`+3.
- Reset mid-handler:
  - stimulus: `rst` pulsed during HANDLER;
  - response: next cycle `in_isr`=0, `jisr`=0, `pend`=0, `mca`=0.
- With `ISR_CTRL_NEST_EN`:
  - stimulus: while servicing `eca`=6, `ca[0]` pulses;
  - response: nested `jisr` with `eca`=0;
  - first `eret` restores `eca`=6 with `in_isr`=1; second `eret` clears `in_isr`.
